// File: rtl/mccoy_seq_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the McCoy 3-bit-opcode core.
// Owns the PC and instruction register, and pulses one stage enable per state.
module mccoy_seq_ctrl #(
    parameter int PC_W  = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    output logic             instr_req,
    output logic [PC_W-1:0]  instr_addr,
    input  logic             instr_valid,
    input  logic [7:0]       instr_data,
    output logic [2:0]       opcode,
    output logic [4:0]       operand,
    input  logic             bez,
    input  logic             ja,
    input  logic             zero,
    input  logic [PC_W-1:0]  target,
    output logic             dec_en,
    output logic             ex_en,
    output logic             wb_en,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      ir;
    logic [PC_W-1:0] npc;
    logic [PC_W-1:0] npc_nxt;
    logic            take_target;

    // Fetch handshake: instr_req rises on entry to FETCH and stays high with
    // instr_addr stable until a cycle in which instr_valid is high; that edge
    // loads ir and ends the transfer. instr_valid in any other state is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (run || step) state_nxt = S_FETCH;
            S_FETCH:  if (instr_valid) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Stage strobes are Moore outputs, so at most one is ever high.
    always_comb begin
        instr_req = 1'b0;
        dec_en    = 1'b0;
        ex_en     = 1'b0;
        wb_en     = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_IDLE:   busy      = 1'b0;
            S_FETCH:  instr_req = 1'b1;
            S_DECODE: dec_en    = 1'b1;
            S_EXEC:   ex_en     = 1'b1;
            S_WB:     wb_en     = 1'b1;
            default:  busy      = 1'b0;
        endcase
    end

    // ja wins over bez; bez only redirects when the datapath reports zero.
    assign take_target = ja || (bez && zero);
    assign npc_nxt     = take_target ? target : pc + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 8'h00;
        end else if (state == S_FETCH && instr_valid) begin
            ir <= instr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npc <= '0;
        end else if (state == S_EXEC) begin
            npc <= npc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            retired <= '0;
        end else if (state == S_WB) begin
            pc      <= npc;
            retired <= retired + CNT_W'(1);
        end
    end

    assign instr_addr = pc;
    assign opcode     = ir[7:5];
    assign operand    = ir[4:0];
    assign state_dbg  = state;

endmodule
